// File: rtl/cdc_event_scheduler.sv
// Serialises one-cycle event requests from N_REQ sources onto one shared pulse-synchronizer channel.
// Latency: a lone request reaches chan_pulse two edges after it is captured; one transfer is in flight at a time.
// Backpressure: none upstream; a repeat request against a pending flag is reported on drop.
module cdc_event_scheduler #(
    parameter int N_REQ = 4,
    parameter int GUARD = 2,
    parameter int TMO   = 64,
    localparam int IDW  = $clog2(N_REQ)
) (
    input  logic             aclk,
    input  logic             arst_n,
    input  logic [N_REQ-1:0] req_pulse,
    input  logic             chan_busy,
    output logic             chan_pulse,
    output logic [IDW-1:0]   chan_id,
    output logic [N_REQ-1:0] pend,
    output logic [N_REQ-1:0] drop,
    output logic             tmo_err,
    output logic             idle
);

    localparam int IDW1 = IDW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_REL,
        S_HOLD
    } state_t;

    state_t           state, state_nxt;
    logic [9:0]       cnt, cnt_nxt;
    logic             armed, armed_nxt;
    logic [IDW-1:0]   last_grant, last_nxt, id_nxt, winner;
    logic [IDW1-1:0]  idx_sum;
    logic             found, tmo_nxt;
    logic [N_REQ-1:0] clr, pend_nxt, drop_nxt;

    // Round-robin search starting one past the previous grant.
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        idx_sum = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx_sum = IDW1'(last_grant) + IDW1'(off);
            if (idx_sum >= IDW1'(N_REQ)) begin
                idx_sum = idx_sum - IDW1'(N_REQ);
            end
            if (!found && pend[idx_sum[IDW-1:0]]) begin
                winner = idx_sum[IDW-1:0];
                found  = 1'b1;
            end
        end
    end

    // A new request beats the ISSUE clear of the same flag.
    always_comb begin
        clr = '0;
        if (state == S_ISSUE) begin
            clr[chan_id] = 1'b1;
        end
        pend_nxt = (pend & ~clr) | req_pulse;
        drop_nxt = req_pulse & pend & ~clr;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        armed_nxt = armed;
        id_nxt    = chan_id;
        last_nxt  = last_grant;
        tmo_nxt   = 1'b0;
        case (state)
            // IDLE spends one settle cycle seeing work before arbitrating.
            S_IDLE: begin
                if (pend != '0) begin
                    if (armed) begin
                        state_nxt = S_ISSUE;
                        id_nxt    = winner;
                        armed_nxt = 1'b0;
                    end else begin
                        armed_nxt = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                last_nxt  = chan_id;
                cnt_nxt   = '0;
                state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (chan_busy) begin
                    state_nxt = S_WAIT_REL;
                end else if (cnt == 10'(TMO - 1)) begin
                    tmo_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = (GUARD == 0) ? S_IDLE : S_HOLD;
                end else begin
                    cnt_nxt = cnt + 10'd1;
                end
            end
            S_WAIT_REL: begin
                if (!chan_busy) begin
                    cnt_nxt   = '0;
                    state_nxt = (GUARD == 0) ? S_IDLE : S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt == 10'(GUARD - 1)) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 10'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            armed      <= 1'b0;
            chan_id    <= '0;
            last_grant <= IDW'(N_REQ - 1);
            pend       <= '0;
            drop       <= '0;
            tmo_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            armed      <= armed_nxt;
            chan_id    <= id_nxt;
            last_grant <= last_nxt;
            pend       <= pend_nxt;
            drop       <= drop_nxt;
            tmo_err    <= tmo_nxt;
        end
    end

    assign chan_pulse = (state == S_ISSUE);
    assign idle       = (state == S_IDLE) && (pend == '0);

endmodule

// File: tb/tb_cdc_event_scheduler.sv
// Bench for cdc_event_scheduler: timestamp-based scheduler model plus directed literal expectations.
module tb_cdc_event_scheduler;

    localparam int N = 4;
    localparam int G = 2;
    localparam int T = 64;

    logic       aclk, arst_n;
    logic [3:0] req, pend, drop;
    logic       busy, chan_pulse, tmo_err, idle;
    logic [1:0] chan_id;
    logic [3:0] req0, pend0, drop0;
    logic       busy0, p0, tmo0, idle0;
    logic [1:0] id0;

    cdc_event_scheduler #(.N_REQ(4), .GUARD(2), .TMO(64)) dut (
        .aclk(aclk), .arst_n(arst_n), .req_pulse(req), .chan_busy(busy),
        .chan_pulse(chan_pulse), .chan_id(chan_id), .pend(pend), .drop(drop),
        .tmo_err(tmo_err), .idle(idle)
    );

    cdc_event_scheduler #(.N_REQ(4), .GUARD(0), .TMO(64)) dut_g0 (
        .aclk(aclk), .arst_n(arst_n), .req_pulse(req0), .chan_busy(busy0),
        .chan_pulse(p0), .chan_id(id0), .pend(pend0), .drop(drop0),
        .tmo_err(tmo0), .idle(idle0)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Model: a transfer owns the channel from its issue edge until release or
    // timeout; after that the scheduler is free GUARD edges later, and an issue
    // happens two edges after the scheduler is free and has work.
    int         cyc = 0;
    logic [3:0] m_pend, m_prev, m_drop, m_clr;
    logic       m_pulse, m_tmo, m_active, m_acked, m_idle, pulse_n, tmo_n, found;
    logic [1:0] m_id, m_last;
    int         m_free, m_issue, c;

    always @(posedge aclk) begin
        cyc++;
        if (!arst_n) begin
            m_pend = '0; m_prev = '0; m_drop = '0; m_pulse = 1'b0; m_tmo = 1'b0;
            m_id = 2'd0; m_last = 2'd3; m_free = -100; m_issue = 0;
            m_active = 1'b0; m_acked = 1'b0; m_idle = 1'b1;
        end else begin
            m_clr = '0; pulse_n = 1'b0; tmo_n = 1'b0;
            if (m_pulse) begin
                m_clr[m_id] = 1'b1;
                m_last = m_id;
            end
            if (m_active && cyc > m_issue + 1) begin
                if (!m_acked) begin
                    if (busy) m_acked = 1'b1;
                    else if (cyc == m_issue + 1 + T) begin
                        tmo_n = 1'b1; m_active = 1'b0; m_free = cyc + G;
                    end
                end else if (!busy) begin
                    m_active = 1'b0; m_free = cyc + G;
                end
            end
            if (!m_active && cyc - 2 >= m_free && m_prev != '0) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    c = (int'(m_last) + k) % N;
                    if (!found && m_pend[c]) begin
                        m_id = 2'(c); found = 1'b1;
                    end
                end
                m_active = 1'b1; m_acked = 1'b0; m_issue = cyc; pulse_n = 1'b1;
            end
            m_drop  = req & m_pend & ~m_clr;
            m_prev  = m_pend;
            m_pend  = (m_pend & ~m_clr) | req;
            m_pulse = pulse_n;
            m_tmo   = tmo_n;
            m_idle  = !m_active && cyc >= m_free && m_pend == '0;
        end
    end

    // Channel responder: busy rises ack_dly edges after the pulse, held hold_len.
    int ack_dly = 3, hold_len = 5;
    bit auto_ack = 1'b1;
    initial begin
        busy = 1'b0;
        forever begin
            @(posedge aclk); #1;
            if (auto_ack && chan_pulse) begin
                repeat (ack_dly) @(posedge aclk);
                #1 busy = 1'b1;
                repeat (hold_len) @(posedge aclk);
                #1 busy = 1'b0;
            end
        end
    end

    int checks = 0, passed = 0, drop1 = 0;
    int glog[$], gtime[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Every cycle goes through here: monitor plus model comparison.
    task automatic tick();
        @(posedge aclk); #1;
        if (arst_n) begin
            chk("m_pulse", int'(chan_pulse), int'(m_pulse));
            chk("m_id",    int'(chan_id),    int'(m_id));
            chk("m_pend",  int'(pend),       int'(m_pend));
            chk("m_drop",  int'(drop),       int'(m_drop));
            chk("m_tmo",   int'(tmo_err),    int'(m_tmo));
            chk("m_idle",  int'(idle),       int'(m_idle));
            if (chan_pulse) begin
                glog.push_back(int'(chan_id));
                gtime.push_back(cyc);
            end
            if (drop[1]) drop1++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        #2 arst_n = 1'b0;
        ticks(3);
        #2 arst_n = 1'b1;
        tick();
    endtask

    int m, d, ones;

    initial begin
        arst_n = 1'b0; req = '0; req0 = '0; busy0 = 1'b0;
        ticks(3);
        #2 arst_n = 1'b1;
        tick();
        chk("rst_pulse", int'(chan_pulse), 0);
        chk("rst_idle",  int'(idle), 1);
        chk("rst_id",    int'(chan_id), 0);
        chk("rst_pend",  int'(pend), 0);
        chk("rst_drop",  int'(drop), 0);
        chk("rst_tmo",   int'(tmo_err), 0);

        // Single request, latency and guard
        req = 4'b0100; tick(); req = '0;
        chk("t1_pend_set", int'(pend), 4);
        chk("t1_pulse_k",  int'(chan_pulse), 0);
        tick(); chk("t1_pulse_k1", int'(chan_pulse), 0);
        tick(); chk("t1_pulse_k2", int'(chan_pulse), 1);
        chk("t1_id", int'(chan_id), 2);
        tick(); chk("t1_pend_clr", int'(pend), 0);
        ticks(9); chk("t1_idle_hold", int'(idle), 0);
        tick(); chk("t1_idle_back", int'(idle), 1);
        ticks(5);

        // All four at once after reset
        do_reset();
        m = glog.size();
        req = 4'b1111; tick(); req = '0;
        ticks(70);
        chk("t2_count", glog.size() - m, 4);
        if (glog.size() - m == 4) begin
            for (int i = 0; i < 4; i++) chk("t2_order", glog[m + i], i);
            chk("t2_spacing", gtime[m + 1] - gtime[m], 13);
        end

        // Drops while pending
        m = glog.size(); d = drop1;
        req = 4'b0001; tick(); req = '0;
        ticks(3);
        req = 4'b0010; tick(); req = '0; tick();
        req = 4'b0010; tick(); req = '0; tick();
        req = 4'b0010; tick(); req = '0;
        ticks(40);
        chk("t3_drops", drop1 - d, 2);
        chk("t3_count", glog.size() - m, 2);
        ones = 0;
        for (int i = m; i < glog.size(); i++) if (glog[i] == 1) ones++;
        chk("t3_req1_once", ones, 1);

        // Request arriving in its own ISSUE cycle
        m = glog.size();
        req = 4'b0010; tick(); req = '0;
        tick(); tick();
        chk("t3b_pulse", int'(chan_pulse), 1);
        req = 4'b0010; tick(); req = '0;
        chk("t3b_pend", int'(pend), 2);
        chk("t3b_nodrop", int'(drop), 0);
        ticks(30);
        chk("t3b_count", glog.size() - m, 2);
        if (glog.size() - m == 2) begin
            chk("t3b_id_a", glog[m], 1);
            chk("t3b_id_b", glog[m + 1], 1);
        end

        // Acknowledge timeout
        do_reset();
        auto_ack = 1'b0;
        req = 4'b0101; tick(); req = '0;
        ticks(2);
        chk("t4_pulse", int'(chan_pulse), 1);
        chk("t4_id0", int'(chan_id), 0);
        ticks(64); chk("t4_tmo_early", int'(tmo_err), 0);
        tick();    chk("t4_tmo", int'(tmo_err), 1);
        chk("t4_pend", int'(pend), 4);
        auto_ack = 1'b1;
        tick();    chk("t4_tmo_once", int'(tmo_err), 0);
        ticks(3);
        chk("t4_next_pulse", int'(chan_pulse), 1);
        chk("t4_next_id", int'(chan_id), 2);
        tick(); chk("t4_discarded", int'(pend), 0);
        ticks(20);

        // Reset in WAIT_REL
        do_reset();
        hold_len = 20;
        req = 4'b1011; tick(); req = '0;
        ticks(2); chk("t5_id0", int'(chan_id), 0);
        ticks(6); chk("t5_pend", int'(pend), 10);
        #2 arst_n = 1'b0;
        ticks(2);
        #2 arst_n = 1'b1;
        tick();
        chk("t5_rst_pend", int'(pend), 0);
        chk("t5_rst_idle", int'(idle), 1);
        chk("t5_rst_pulse", int'(chan_pulse), 0);
        chk("t5_rst_id", int'(chan_id), 0);
        m = glog.size();
        ticks(30);
        chk("t5_no_pulse", glog.size() - m, 0);
        hold_len = 5;
        req = 4'b1000; tick(); req = '0;
        ticks(2);
        chk("t5_new_pulse", int'(chan_pulse), 1);
        chk("t5_new_id", int'(chan_id), 3);
        ticks(15);

        // GUARD=0 build
        req0 = 4'b1010; tick(); req0 = '0;
        ticks(2);
        chk("g0_pulse", int'(p0), 1);
        chk("g0_id", int'(id0), 1);
        busy0 = 1'b1; ticks(4);
        busy0 = 1'b0; tick();
        chk("g0_fall_pulse", int'(p0), 0);
        chk("g0_fall_idle", int'(idle0), 0);
        chk("g0_pend", int'(pend0), 8);
        chk("g0_drop", int'(drop0), 0);
        chk("g0_tmo", int'(tmo0), 0);
        tick(); chk("g0_pulse_j1", int'(p0), 0);
        tick(); chk("g0_pulse_j2", int'(p0), 1);
        chk("g0_id2", int'(id0), 3);
        ticks(3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cdc_event_scheduler.md
CDC_EVENT_SCHEDULER -- requirements
Module: cdc_event_scheduler

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of event requesters (2..16).
REQ-002 The block SHALL have parameter GUARD, default 2, giving the idle cycles forced between channel releases and the next issue (0..15).
REQ-003 The block SHALL have parameter TMO, default 64, giving the cycles allowed for chan_busy to rise after an issue (2..1023).
REQ-004 aclk  in  1  Single clock; all logic on its rising edge.
REQ-005 arst_n  in  1  Asynchronous, active-low reset; asserts immediately, releases synchronously to aclk.
REQ-006 req_pulse  in  N_REQ  One-cycle event request per requester, aclk domain.
REQ-007 chan_busy  in  1  Shared pulse-synchronizer channel busy level, already in the aclk domain.
REQ-008 chan_pulse  out  1  One-cycle pulse into the shared channel.
REQ-009 chan_id  out  clog2(N_REQ)  Index of the requester owning the current or most recent transfer.
REQ-010 pend  out  N_REQ  Pending-event flags.
REQ-011 drop  out  N_REQ  One-cycle flag: request lost because that requester was already pending.
REQ-012 tmo_err  out  1  One-cycle flag: chan_busy did not rise within TMO cycles.
REQ-013 idle  out  1  High only when FSM is in IDLE and pend is all zero.

Function
REQ-014 req_pulse[i] high at an edge SHALL set pend[i] at that edge.
REQ-015 req_pulse[i] high while pend[i] is already 1 and not being cleared that edge SHALL keep pend[i]=1 and assert drop[i] for exactly the next cycle.
REQ-016 A set and a clear of pend[i] at the same edge SHALL resolve as set; drop[i] SHALL NOT assert.
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT_ACK, WAIT_REL and HOLD.
REQ-018 IDLE: if pend is nonzero, the FSM SHALL select a winner round-robin starting at last_grant+1 mod N_REQ, load chan_id, and go to ISSUE.
REQ-019 ISSUE (exactly one cycle): chan_pulse SHALL be 1 and pend[chan_id] SHALL be cleared; next state WAIT_ACK with the timeout counter set to 0.
REQ-020 chan_pulse SHALL be 0 in every state except ISSUE.
REQ-021 WAIT_ACK: chan_busy=1 SHALL go to WAIT_REL.
REQ-022 WAIT_ACK: after TMO cycles without chan_busy, tmo_err SHALL pulse once, the event SHALL be discarded (not re-pended), and the FSM SHALL go to HOLD.
REQ-023 WAIT_REL: chan_busy=0 SHALL go to HOLD, or to IDLE when GUARD=0.
REQ-024 HOLD SHALL last exactly GUARD cycles, then go to IDLE.
REQ-025 last_grant SHALL update to chan_id on leaving ISSUE.
REQ-026 chan_id SHALL hold its value from ISSUE until the next ISSUE.
REQ-027 Latency: req_pulse sampled at edge k with the FSM in IDLE and no other pend SHALL give chan_pulse high between edges k+2 and k+3.
REQ-028 Requests SHALL continue to be captured in all states.

Reset
REQ-029 On arst_n=0: state IDLE, pend=0, drop=0, chan_pulse=0, tmo_err=0, chan_id=0, counters=0, last_grant=N_REQ-1 (so requester 0 has first priority), idle=1.
REQ-030 Reset asserted mid-transfer SHALL discard all pending events and the in-flight grant; no chan_pulse SHALL appear until new requests arrive after release.

Verification
REQ-031 Single req_pulse[2], chan_busy rising 3 cycles after the issue and held 5 cycles -> one chan_pulse, chan_id=2, pend[2] cleared in ISSUE, idle=1 after GUARD=2 hold cycles.
REQ-032 req_pulse=4'b1111 in one cycle after reset -> grants in order 0,1,2,3, one chan_pulse each, each issue only after the previous busy falls plus 2 HOLD cycles.
REQ-033 req_pulse[1] twice while pend[1]=1 -> drop[1] pulses twice and exactly one transfer occurs for requester 1; req_pulse[1] in its own ISSUE cycle -> pend[1] stays 1, no drop, and a second transfer follows.
REQ-034 chan_busy held 0 after an issue -> tmo_err pulses after 64 cycles, FSM in HOLD then IDLE, next pending requester served.
REQ-035 arst_n pulsed low while in WAIT_REL with pend=4'b1010 -> all outputs at reset values, no chan_pulse afterward until a new request arrives.
REQ-036 GUARD=0 build: busy fall -> IDLE next cycle, next chan_pulse 2 cycles after the busy fall.
